// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: accepts a parallel word and shifts it out MSB-first on w,
// followed by a fixed idle gap, to drive the single-bit input of sequence detectors.
module serial_pattern_tx #(
  parameter int   WIDTH      = 8,
  parameter int   GAP_CYCLES = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       load,
  output logic                       ready,
  output logic                       w,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] bit_count,
  output logic [1:0]                 State_out
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SHIFT   = 2'b01,
    GAP     = 2'b10,
    ILLEGAL = 2'b11
  } state_e;

  state_e           state_q, state_d;
  // The MSB goes straight to w at acceptance, so only the remaining bits are held here.
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [CW-1:0]    bitCount_q, bitCount_d;
  logic [3:0]       gapCnt_q, gapCnt_d;
  logic             w_q, w_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitCount_d = bitCount_q;
    gapCnt_d   = gapCnt_q;
    w_d        = IDLE_LEVEL;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d    = SHIFT;
          shift_d    = data_in[WIDTH-2:0];
          w_d        = data_in[WIDTH-1];
          bitCount_d = CW'(WIDTH);
        end
      end
      SHIFT: begin
        if (bitCount_q > CW'(1)) begin
          w_d        = shift_q[WIDTH-2];
          shift_d    = shift_q << 1;
          bitCount_d = bitCount_q - CW'(1);
        end else begin
          // Last bit has been on w for its cycle: flag the frame end and enter the gap.
          bitCount_d = '0;
          shift_d    = '0;
          done_d     = 1'b1;
          gapCnt_d   = 4'(GAP_CYCLES);
          state_d    = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gapCnt_q <= 4'd1) begin
          gapCnt_d = '0;
          state_d  = IDLE;
        end else begin
          gapCnt_d = gapCnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ready     = (state_q == IDLE);
    busy      = (state_q != IDLE);
    State_out = state_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      bitCount_q <= '0;
      gapCnt_q   <= '0;
      w_q        <= IDLE_LEVEL;
      done_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bitCount_q <= bitCount_d;
      gapCnt_q   <= gapCnt_d;
      w_q        <= w_d;
      done_q     <= done_d;
    end
  end

  assign w         = w_q;
  assign done      = done_q;
  assign bit_count = bitCount_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: one instance with a 2-cycle gap, one with no gap.
module tb_serial_pattern_tx;

  typedef struct {
    int   cyc;
    logic w;
    int   bc;
    logic chkZ;
    logic z;
  } bit_t;

  logic       clk = 1'b0;
  logic       rst, rst0;
  logic [7:0] dataIn, dataIn0;
  logic       load, load0;
  logic       ready, w, busy, done;
  logic       ready0, w0, busy0, done0;
  logic [3:0] bitCount, bitCount0;
  logic [1:0] st, st0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int prevDone0 = -1;

  bit_t bitQ[$];
  bit_t bitQ0[$];
  int   doneQ[$];
  int   doneQ0[$];

  serial_pattern_tx #(.WIDTH(8), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .reset(rst), .data_in(dataIn), .load(load), .ready(ready), .w(w),
    .busy(busy), .done(done), .bit_count(bitCount), .State_out(st)
  );

  serial_pattern_tx #(.WIDTH(8), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .reset(rst0), .data_in(dataIn0), .load(load0), .ready(ready0), .w(w0),
    .busy(busy0), .done(done0), .bit_count(bitCount0), .State_out(st0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Issue one load; queue the expected bits (first nbits of the frame) and, for a full frame, the done pulse.
  task automatic applyStimulus(input int unit, input logic [7:0] data, input int nbits,
                               input logic chkZ, input logic [7:0] zPat);
    int acc;
    bit_t e;
    @(negedge clk);
    if (unit == 0) begin
      load = 1'b1; dataIn = data;
    end else begin
      load0 = 1'b1; dataIn0 = data;
    end
    @(posedge clk);
    #1;
    load  = 1'b0;
    load0 = 1'b0;
    acc   = cyc;
    for (int k = 1; k <= nbits; k++) begin
      e.cyc  = acc + k - 1;
      e.w    = data[8-k];
      e.bc   = 9 - k;
      e.chkZ = chkZ;
      e.z    = zPat[8-k];
      if (unit == 0) bitQ.push_back(e);
      else bitQ0.push_back(e);
    end
    if (nbits == 8) begin
      if (unit == 0) doneQ.push_back(acc + 8);
      else doneQ0.push_back(acc + 8);
    end
  endtask

  // Monitor for the gapped instance, with a "0110" detector fed from w every cycle.
  initial begin
    logic [3:0] hist;
    logic       zNow;
    bit_t       e;
    int         d;
    hist = 4'b0000;
    forever begin
      @(negedge clk);
      zNow = ({hist[2:0], w} == 4'b0110);
      hist = {hist[2:0], w};
      if (st == 2'b01) begin
        checkOutput("shift bit expected", bitQ.size() != 0, 1);
        if (bitQ.size() != 0) begin
          e = bitQ.pop_front();
          checkOutput("bit cycle", cyc, e.cyc);
          checkOutput("w bit", w, e.w);
          checkOutput("bit_count", bitCount, e.bc);
          if (e.chkZ) checkOutput("detector z", zNow, e.z);
        end
      end
      if (st == 2'b10) begin
        checkOutput("gap w", w, 0);
        checkOutput("gap ready", ready, 0);
        checkOutput("gap busy", busy, 1);
      end
      if (done) begin
        checkOutput("done expected", doneQ.size() != 0, 1);
        if (doneQ.size() != 0) begin
          d = doneQ.pop_front();
          checkOutput("done cycle", cyc, d);
          checkOutput("done w", w, 0);
          checkOutput("done bit_count", bitCount, 0);
          checkOutput("done state", st, 2'b10);
        end
      end
    end
  end

  // Monitor for the zero-gap instance.
  initial begin
    bit_t e;
    int   d;
    forever begin
      @(negedge clk);
      if (st0 == 2'b01) begin
        checkOutput("shift0 bit expected", bitQ0.size() != 0, 1);
        if (bitQ0.size() != 0) begin
          e = bitQ0.pop_front();
          checkOutput("bit0 cycle", cyc, e.cyc);
          checkOutput("w0 bit", w0, e.w);
          checkOutput("bit_count0", bitCount0, e.bc);
        end
      end
      if (done0) begin
        checkOutput("done0 expected", doneQ0.size() != 0, 1);
        if (doneQ0.size() != 0) begin
          d = doneQ0.pop_front();
          checkOutput("done0 cycle", cyc, d);
          checkOutput("done0 w", w0, 0);
          checkOutput("done0 state", st0, 2'b00);
          checkOutput("done0 ready", ready0, 1);
        end
        if (prevDone0 >= 0) checkOutput("done0 spacing", cyc - prevDone0, 9);
        prevDone0 = cyc;
      end
    end
  end

  task automatic checkIdle(input string tag);
    checkOutput({tag, " w"}, w, 0);
    checkOutput({tag, " ready"}, ready, 1);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " done"}, done, 0);
    checkOutput({tag, " state"}, st, 2'b00);
  endtask

  initial begin
    rst = 1'b1; rst0 = 1'b1;
    load = 1'b0; load0 = 1'b0;
    dataIn = 8'h00; dataIn0 = 8'h00;

    // Reset for two cycles, then three idle cycles.
    @(negedge clk); checkIdle("reset1");
    @(negedge clk); checkIdle("reset2");
    rst = 1'b0; rst0 = 1'b0;
    repeat (3) begin
      @(negedge clk); checkIdle("idle");
    end

    // A5 frame; an ignored FF load in cycle 3.
    applyStimulus(0, 8'hA5, 8, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    load = 1'b1; dataIn = 8'hFF;
    @(posedge clk); #1; load = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    checkOutput("cycle11 ready", ready, 1);
    checkOutput("cycle11 state", st, 2'b00);
    repeat (3) @(negedge clk);

    // F0 frame aborted by reset in cycle 4.
    applyStimulus(0, 8'hF0, 4, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort w", w, 0);
    checkOutput("abort state", st, 2'b00);
    checkOutput("abort ready", ready, 1);
    repeat (12) @(negedge clk);

    // 01100110 through the detector: z fires on bits 4 and 8.
    applyStimulus(0, 8'b01100110, 8, 1'b1, 8'b00010001);
    repeat (14) @(negedge clk);

    // Zero-gap back-to-back frames, second load in the done cycle.
    applyStimulus(1, 8'hC3, 8, 1'b0, 8'h00);
    repeat (8) @(posedge clk);
    applyStimulus(1, 8'h3C, 8, 1'b0, 8'h00);
    repeat (12) @(negedge clk);

    checkOutput("leftover bits", bitQ.size(), 0);
    checkOutput("leftover done", doneQ.size(), 0);
    checkOutput("leftover bits0", bitQ0.size(), 0);
    checkOutput("leftover done0", doneQ0.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
Serial pattern transmitter that drives the single-bit `w` stream consumed by our sequence-detector FSMs. It is the sending end of the `w` interface. It accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per clock. After each frame it holds an idle gap, so benches and top-levels can drive detectors with exact, repeatable bit patterns.

Parameters:
WIDTH, 8, bits per frame (legal range 2..32)
GAP_CYCLES, 2, idle cycles inserted after each frame (legal range 0..15)
IDLE_LEVEL, 0, value driven on w whenever no frame bit is being sent

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
data_in  input  WIDTH  frame to transmit; bit WIDTH-1 is sent first
load  input  1  request to start a frame; accepted only when ready=1
ready  output  1  high when a load will be accepted this cycle
w  output  1  registered serial output
busy  output  1  high while in SHIFT or GAP
done  output  1  one-cycle pulse marking end of the frame's last bit
bit_count  output  $clog2(WIDTH+1)  bits remaining in the current frame, including the bit now on w
State_out  output  2  current FSM state encoding, for debug/LEDs

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (ports `clk`, `reset`).
- FSM states and encodings: IDLE=2'b00, SHIFT=2'b01, GAP=2'b10. 2'b11 is illegal and returns to IDLE on the next edge.
- Reset values: state=IDLE, w=IDLE_LEVEL, shift register=0, bit_count=0, gap counter=0, done=0, busy=0, ready=1.
- Reset behaviour:
  - Reset dominates load.
  - Reset mid-frame or mid-gap aborts immediately at that edge: no done pulse, and w returns to IDLE_LEVEL the following cycle.
- ready: equals (state==IDLE) and is combinational from state.
- busy: equals (state!=IDLE).
- Acceptance at edge E0 (load=1, ready=1):
  - data_in is captured into the shift register.
  - State becomes SHIFT.
  - Throughout cycle 1 (the cycle after E0), w=data_in[WIDTH-1] and bit_count=WIDTH.
- SHIFT:
  - Each edge shifts left by one and decrements bit_count.
  - In cycle k (1..WIDTH), w=data_in[WIDTH-k].
  - At the edge ending cycle WIDTH, the FSM goes to GAP if GAP_CYCLES>0, otherwise to IDLE.
- Frame end (cycle WIDTH+1):
  - done=1 for exactly one cycle.
  - w=IDLE_LEVEL.
  - bit_count=0.
- GAP:
  - Lasts exactly GAP_CYCLES cycles (cycles WIDTH+1 .. WIDTH+GAP_CYCLES).
  - w=IDLE_LEVEL and ready=0 throughout.
  - The FSM then enters IDLE.
- load outside IDLE: ignored entirely and not queued. data_in changes during SHIFT do not affect w.
- Back-to-back frames with GAP_CYCLES=0:
  - Cycle WIDTH+1 is IDLE with done=1 and ready=1.
  - A load accepted there puts the next frame's first bit on w in cycle WIDTH+2.
  - The minimum inter-frame spacing is therefore one IDLE_LEVEL cycle.
- Register outputs: w, done, and bit_count are registered; no combinational path exists from load or data_in to w.
- Latency: the first bit appears 1 cycle after acceptance. A frame occupies WIDTH+GAP_CYCLES+1 cycles from acceptance to ready.

Test Plan:
1. Reset for 2 cycles, then idle for 3 cycles -> w=0, ready=1, busy=0, done=0, State_out=00 on every cycle.
2. WIDTH=8, GAP=2; load=1 with data_in=8'hA5 at E0 ->
   - cycles 1..8: w = 1,0,1,0,0,1,0,1 and bit_count = 8..1;
   - cycle 9: done=1;
   - cycles 9-10: State_out=10, w=0;
   - cycle 11: ready=1.
3. During the 8'hA5 frame, pulse load with data_in=8'hFF at cycle 3 -> transmitted bits are unchanged (A5), and no second frame starts.
4. GAP=0; load 8'hC3, then load 8'h3C in the done cycle ->
   - w = 1,1,0,0,0,0,1,1, then one cycle of 0, then 0,0,1,1,1,1,0,0;
   - two done pulses, 9 cycles apart.
5. Assert reset in cycle 4 of an 8'hF0 frame -> from cycle 5: w=0, State_out=00, ready=1; no done pulse ever appears for that frame.
6. Connect w to a sequence-detector instance and send 8'b01100110 -> the detector's z output matches the golden model's z for that bit stream, cycle for cycle.
